dm_port_arbiter: RTL and testbench

Two-port arbiter that shares the single read/write port of the data memory between the CPU datapath (port 0) and a host/debug loader (port 1). It grants at most one access per cycle and drives the memory's write enable, address and write data. It returns read data to the winning port one cycle later, matching the memory's registered-address read. Ownership is sticky for bounded bursts and alternates round-robin under contention, so neither port starves.

---
 rtl/dm_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter sharing the data-memory read/write port between the CPU (port 0)
// and the host loader (port 1): sticky bounded bursts, round-robin under contention.
module dm_port_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic [1:0]    dbg_state_o
);

  // Handshake: a port holds req/we/addr/wdata stable until its gnt; gnt means the
  // command reaches memory this cycle. A granted read answers with an rvalid pulse
  // on the following cycle, with rdata valid only while that pulse is high.

  localparam int CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tag_vld_q, tag_vld_d;
  logic          tag_port_q, tag_port_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic          busy_q;

  logic win_vld;
  logic win_port;

  always_comb begin
    win_vld  = 1'b0;
    win_port = 1'b0;
    if (!rst) begin
      case (state_q)
        S_OWN0: begin
          if (req0 && (!req1 || cnt_q < BMAX)) begin
            win_vld  = 1'b1;
            win_port = 1'b0;
          end else if (req1) begin
            win_vld  = 1'b1;
            win_port = 1'b1;
          end
        end
        S_OWN1: begin
          if (req1 && (!req0 || cnt_q < BMAX)) begin
            win_vld  = 1'b1;
            win_port = 1'b1;
          end else if (req0) begin
            win_vld  = 1'b1;
            win_port = 1'b0;
          end
        end
        default: begin
          // On a tie from idle the port that was not served last goes first.
          if (req0 && req1) begin
            win_vld  = 1'b1;
            win_port = ~last_q;
          end else if (req0) begin
            win_vld  = 1'b1;
            win_port = 1'b0;
          end else if (req1) begin
            win_vld  = 1'b1;
            win_port = 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt0 = win_vld & ~win_port;
  assign gnt1 = win_vld &  win_port;

  always_comb begin
    mem_wea  = 1'b0;
    mem_addr = addr_hold_q;
    mem_din  = '0;
    if (win_vld) begin
      mem_wea  = win_port ? we1    : we0;
      mem_addr = win_port ? addr1  : addr0;
      mem_din  = win_port ? wdata1 : wdata0;
    end
  end

  always_comb begin
    state_d     = S_IDLE;
    last_d      = last_q;
    cnt_d       = '0;
    addr_hold_d = addr_hold_q;
    tag_vld_d   = 1'b0;
    tag_port_d  = tag_port_q;
    if (win_vld) begin
      state_d     = win_port ? S_OWN1 : S_OWN0;
      last_d      = win_port;
      addr_hold_d = mem_addr;
      tag_vld_d   = ~mem_wea;
      tag_port_d  = win_port;
      if (state_q == state_d) begin
        cnt_d = (cnt_q == BMAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      tag_vld_q   <= 1'b0;
      tag_port_q  <= 1'b0;
      addr_hold_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      tag_port_q  <= tag_port_d;
      addr_hold_q <= addr_hold_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  // A read granted just before reset is dropped: its pulse is masked while rst is high.
  assign rvalid0     = tag_vld_q & ~tag_port_q & ~rst;
  assign rvalid1     = tag_vld_q &  tag_port_q & ~rst;
  assign rdata       = (rvalid0 | rvalid1) ? mem_dout : '0;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a registered-address memory model.
module tb_dm_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_wea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [256];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int checks;
  int errors;

  dm_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  // Clock and reset-time memory preload.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_wea) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) next_cycle();
    rst = 1'b0;
  endtask

  int exp_port [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    checks = 0;
    errors = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;

    // Reset: preload memory, outputs quiet.
    pre_we = 1'b1; pre_addr = 8'd10; pre_data = 32'h1234;
    next_cycle();
    pre_addr = 8'd20; pre_data = 32'h0000_0055;
    next_cycle();
    pre_we = 1'b0;
    to_mid();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_wea", mem_wea, 0);
    next_cycle();
    rst = 1'b0;
    to_mid();
    check("rst_busy", busy, 0);
    check("rst_rvalid", {rvalid1, rvalid0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_state", dbg_state, 0);
    next_cycle();

    // Single read from port 0.
    drive0(1'b1, 1'b0, 8'd10, '0);
    to_mid();
    check("rd_gnt0", gnt0, 1);
    check("rd_gnt1", gnt1, 0);
    check("rd_addr", mem_addr, 10);
    check("rd_wea", mem_wea, 0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    to_mid();
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_rdata", rdata, 32'h1234);
    check("rd_busy", busy, 1);
    check("rd_gnt_idle", {gnt1, gnt0}, 0);
    next_cycle();
    to_mid();
    check("rd_pulse_end", rvalid0, 0);
    check("rd_addr_hold", mem_addr, 10);
    next_cycle();

    // Port 1 write then readback of the same address.
    drive1(1'b1, 1'b1, 8'd20, 32'hDEADBEEF);
    to_mid();
    check("wr_gnt1", gnt1, 1);
    check("wr_gnt0", gnt0, 0);
    check("wr_wea", mem_wea, 1);
    check("wr_addr", mem_addr, 20);
    check("wr_din", mem_din, 32'hDEADBEEF);
    next_cycle();
    drive1(1'b1, 1'b0, 8'd20, '0);
    to_mid();
    check("wb_gnt1", gnt1, 1);
    check("wb_no_rvalid", {rvalid1, rvalid0}, 0);
    next_cycle();
    drive1(1'b0, 1'b0, '0, '0);
    to_mid();
    check("wb_rvalid1", rvalid1, 1);
    check("wb_rdata", rdata, 32'hDEADBEEF);
    check("wb_rvalid0", rvalid0, 0);
    next_cycle();

    // Tie right after reset goes to port 0, the re-tie to port 1.
    do_reset(2);
    drive0(1'b1, 1'b1, 8'd30, 32'h30);
    drive1(1'b1, 1'b1, 8'd31, 32'h31);
    to_mid();
    check("tie1_gnt0", gnt0, 1);
    check("tie1_gnt1", gnt1, 0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();
    drive0(1'b1, 1'b1, 8'd30, 32'h30);
    drive1(1'b1, 1'b1, 8'd31, 32'h31);
    to_mid();
    check("tie2_gnt1", gnt1, 1);
    check("tie2_gnt0", gnt0, 0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();

    // Continuous contention with reads: bursts of four alternate.
    drive0(1'b1, 1'b0, 8'd10, '0);
    drive1(1'b1, 1'b0, 8'd20, '0);
    for (int i = 0; i < 10; i++) begin
      to_mid();
      check($sformatf("burst_gnt0_%0d", i), gnt0, (exp_port[i] == 0) ? 1 : 0);
      check($sformatf("burst_gnt1_%0d", i), gnt1, (exp_port[i] == 1) ? 1 : 0);
      if (i > 0) begin
        check($sformatf("burst_rv0_%0d", i), rvalid0, (exp_port[i-1] == 0) ? 1 : 0);
        check($sformatf("burst_rd_%0d", i), rdata, (exp_port[i-1] == 0) ? 32'h1234 : 32'hDEADBEEF);
      end
      next_cycle();
    end
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();

    // Port 0 alone is never throttled.
    drive0(1'b1, 1'b1, 8'd50, 32'h50);
    for (int i = 0; i < 10; i++) begin
      to_mid();
      check($sformatf("solo_gnt0_%0d", i), gnt0, 1);
      next_cycle();
    end
    drive0(1'b0, 1'b0, '0, '0);
    next_cycle();

    // Reset right after a granted read drops the read.
    drive0(1'b1, 1'b0, 8'd10, '0);
    to_mid();
    check("rm_gnt0", gnt0, 1);
    next_cycle();
    rst = 1'b1;
    to_mid();
    check("rm_rvalid0", rvalid0, 0);
    check("rm_gnt_in_rst", {gnt1, gnt0}, 0);
    next_cycle();
    rst = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    to_mid();
    check("rm_rvalid_after", rvalid0, 0);
    check("rm_state", dbg_state, 0);
    check("rm_busy", busy, 0);
    next_cycle();
    drive0(1'b1, 1'b1, 8'd40, 32'h40);
    drive1(1'b1, 1'b1, 8'd41, 32'h41);
    to_mid();
    check("rm_tie_gnt0", gnt0, 1);
    check("rm_tie_gnt1", gnt1, 0);
    next_cycle();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();

    // Idle quiet.
    for (int i = 0; i < 5; i++) begin
      to_mid();
      check($sformatf("idle_wea_%0d", i), mem_wea, 0);
      check($sformatf("idle_gnt_%0d", i), {gnt1, gnt0}, 0);
      check($sformatf("idle_rv_%0d", i), {rvalid1, rvalid0}, 0);
      check($sformatf("idle_busy_%0d", i), busy, 0);
      next_cycle();
    end
    check("mem10_kept", mem[10], 32'h1234);
    check("mem20_kept", mem[20], 32'hDEADBEEF);
    check("mem40_written", mem[40], 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
